dmem_mmio: RTL and testbench
============================

Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle MIPS core.
- Consumes the core's memwrite, aluout (address) and writedata; returns readdata in the same cycle.
- Word-addressed data RAM plus a memory-mapped I/O page: LED register, synchronized switches, free-running cycle counter, and a down-counting timer with sticky expiry and interrupt.

Parameters:
RAM_WORDS, 64, data RAM depth in 32-bit words; power of two.
GPIO_W, 8, width of the LED and switch ports (1..32).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
memwrite  input  1  store strobe from the core; a write occurs at the rising edge while this is high.
addr  input  32  byte address (core aluout); bits [1:0] ignored.
writedata  input  32  store data.
readdata  output  32  load data; combinational from addr and current state.
sw  input  GPIO_W  asynchronous switch inputs.
led  output  GPIO_W  LED register value.
irq  output  1  timer expiry flag, level, equals TIMER_CTRL[2].

Behaviour:
- Decode: addr[31:8] == 24'hFFFFFF selects MMIO; every other address selects RAM.
- RAM access is indexed by addr[log2(RAM_WORDS)+1:2]; higher bits alias.
- RAM: combinational read, synchronous write. Contents are not reset and are X until written.
- MMIO map (offset = addr[7:0]):
  - 0x00 LED: RW, GPIO_W bits, zero-extended on read.
  - 0x04 SW: RO, output of a 2-flop synchronizer on sw.
  - 0x08 CYCLE: RO, 32-bit, +1 every clock, wraps 0xFFFFFFFF -> 0.
  - 0x0C TIMER_LOAD: RW, 32-bit. A write also loads TIMER_COUNT with writedata on the same edge.
  - 0x10 TIMER_CTRL: bit0 EN (RW), bit1 AUTO (RW), bit2 EXP (read; write 1 clears); other bits read 0.
  - 0x14 TIMER_COUNT: RO.
  - Other offsets read 0; writes to them and to RO registers are ignored.
- Timer, evaluated each edge:
  - If EN=1 and COUNT!=0: COUNT decrements.
  - On the 1 -> 0 transition EXP is set. If AUTO=1, COUNT is reloaded with LOAD instead of reaching 0, so the next cycle counts from LOAD (period = LOAD cycles).
  - If EN=1 and COUNT=0 with AUTO=0, the timer holds and EXP does not re-set.
- Write-precedence rules:
  - A LOAD write in the same cycle as a decrement wins, so COUNT = writedata.
  - An EXP set and a W1C clear in the same cycle: set wins, EXP=1.
  - A CTRL write updates EN and AUTO at the edge; the new EN takes effect from the next cycle's decrement.
- Reset (reset=0, immediate, asynchronous):
  - led=0, sync flops=0, CYCLE=0, LOAD=0, COUNT=0, CTRL=0, irq=0.
  - readdata follows decode; RAM is unaffected.
  - Reset asserted mid-count aborts the count; after release the timer stays idle until EN is written.
- No stalls: every access completes in one cycle, and a load in the same cycle as a store to the same address returns the old value.

Test Plan:
- Reset, then sw=8'hA5 held: read 0xFFFFFF04 returns 0 for the first 2 edges, then 0x000000A5. led=0 and irq=0 throughout reset.
- Store 0xDEADBEEF to 0x00000010, then load 0x00000010 and its alias 0x00000010+4*RAM_WORDS: both return 0xDEADBEEF. Same-cycle load while storing returns the old value.
- Write LOAD=3, then CTRL=0x1: COUNT reads 3,2,1,0 on successive cycles. EXP/irq rises on the edge COUNT reaches 0 and stays 1. Writing CTRL=0x5 clears EXP, irq=0, with EN kept.
- Auto-reload: LOAD=2, CTRL=0x3: irq sets every 2 cycles. Issue a W1C on the exact expiry edge: EXP remains 1.
- CYCLE read twice with one idle cycle between returns a difference of 2. Force CYCLE=0xFFFFFFFF, and the next read returns 0.
- Assert reset mid-count (COUNT=5, EN=1): COUNT=0, CTRL=0 and irq=0 immediately without a clock edge. Write led=0xFF then read 0xFFFFFF00: returns 0x000000FF. Read 0xFFFFFF20: returns 0.

Source files
------------

// File: rtl/dmem_mmio.sv
// Data-side memory stage: word-addressed data RAM plus an MMIO page holding
// LEDs, synchronized switches, a free-running cycle counter and a down-counting timer.
module dmem_mmio #(
    parameter int RAM_WORDS = 64,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memwrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [GPIO_W-1:0] sw,
    output logic [GPIO_W-1:0] led,
    output logic              irq
);

    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [5:0] OFF_LED   = 6'h00;
    localparam logic [5:0] OFF_SW    = 6'h01;
    localparam logic [5:0] OFF_CYCLE = 6'h02;
    localparam logic [5:0] OFF_LOAD  = 6'h03;
    localparam logic [5:0] OFF_CTRL  = 6'h04;
    localparam logic [5:0] OFF_COUNT = 6'h05;

    logic [31:0]       ram_q [RAM_WORDS];

    logic [GPIO_W-1:0] led_q,   led_d;
    logic [GPIO_W-1:0] sw_s1_q, sw_s2_q;
    logic [31:0]       cycle_q, cycle_d;
    logic [31:0]       load_q,  load_d;
    logic [31:0]       count_q, count_d;
    logic              en_q,    en_d;
    logic              auto_q,  auto_d;
    logic              exp_q,   exp_d;

    logic              is_mmio;
    logic [5:0]        word_off;
    logic [AW-1:0]     ram_idx;
    logic              ram_we;
    logic              led_we, load_we, ctrl_we;
    logic              expire;

    assign is_mmio  = (addr[31:8] == 24'hFFFFFF);
    assign word_off = addr[7:2];
    assign ram_idx  = addr[AW+1:2];

    assign ram_we  = memwrite && !is_mmio;
    assign led_we  = memwrite && is_mmio && (word_off == OFF_LED);
    assign load_we = memwrite && is_mmio && (word_off == OFF_LOAD);
    assign ctrl_we = memwrite && is_mmio && (word_off == OFF_CTRL);

    // Expiry is the 1 -> 0 step of an enabled count.
    assign expire = en_q && (count_q == 32'd1);

    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        load_d  = load_q;
        count_d = count_q;
        en_d    = en_q;
        auto_d  = auto_q;
        exp_d   = exp_q;

        if (led_we) begin
            led_d = writedata[GPIO_W-1:0];
        end

        if (en_q && (count_q != 32'd0)) begin
            if (expire && auto_q) begin
                count_d = load_q;
            end else begin
                count_d = count_q - 32'd1;
            end
        end

        // A LOAD write overrides any decrement or reload on the same edge.
        if (load_we) begin
            load_d  = writedata;
            count_d = writedata;
        end

        if (ctrl_we) begin
            en_d   = writedata[0];
            auto_d = writedata[1];
            if (writedata[2]) begin
                exp_d = 1'b0;
            end
        end

        // Set after clear so a same-edge expiry beats the W1C.
        if (expire) begin
            exp_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_q   <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            cycle_q <= '0;
            load_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            led_q   <= led_d;
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
            cycle_q <= cycle_d;
            load_q  <= load_d;
            count_q <= count_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            exp_q   <= exp_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[ram_idx] <= writedata;
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (!is_mmio) begin
            readdata = ram_q[ram_idx];
        end else begin
            case (word_off)
                OFF_LED:   readdata = 32'(led_q);
                OFF_SW:    readdata = 32'(sw_s2_q);
                OFF_CYCLE: readdata = cycle_q;
                OFF_LOAD:  readdata = load_q;
                OFF_CTRL:  readdata = {29'd0, exp_q, auto_q, en_q};
                OFF_COUNT: readdata = count_q;
                default:   readdata = 32'd0;
            endcase
        end
    end

    assign led = led_q;
    assign irq = exp_q;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, switch sync, cycle counter,
// timer one-shot/auto-reload/precedence, and asynchronous reset behaviour.
module tb_dmem_mmio;

    localparam int RAM_WORDS = 64;
    localparam int GPIO_W    = 8;

    localparam logic [31:0] A_LED   = 32'hFFFFFF00;
    localparam logic [31:0] A_SW    = 32'hFFFFFF04;
    localparam logic [31:0] A_CYCLE = 32'hFFFFFF08;
    localparam logic [31:0] A_LOAD  = 32'hFFFFFF0C;
    localparam logic [31:0] A_CTRL  = 32'hFFFFFF10;
    localparam logic [31:0] A_COUNT = 32'hFFFFFF14;

    logic              clk;
    logic              reset;
    logic              memwrite;
    logic [31:0]       addr;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [GPIO_W-1:0] sw;
    logic [GPIO_W-1:0] led;
    logic              irq;

    int check_count = 0;
    int fail_count  = 0;

    dmem_mmio #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .sw        (sw),
        .led       (led),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store cycle; returns 1ns after the capturing edge with memwrite low.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic readCheck(input string tag, input logic [31:0] a, input logic [31:0] expected);
        memwrite = 1'b0;
        addr     = a;
        #1;
        checkOutput(tag, readdata, expected);
    endtask

    logic [31:0] v1, v2;

    initial begin
        reset     = 1'b0;
        memwrite  = 1'b0;
        addr      = 32'd0;
        writedata = 32'd0;
        sw        = 8'hA5;

        #2;
        checkOutput("rst_led", 32'(led), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        readCheck("rst_sw", A_SW, 32'h0);
        tick();
        checkOutput("rst_led_edge", 32'(led), 32'h0);
        checkOutput("rst_irq_edge", 32'(irq), 32'h0);
        reset = 1'b1;
        readCheck("sw_edge0", A_SW, 32'h0);
        tick();
        readCheck("sw_edge1", A_SW, 32'h0);
        tick();
        readCheck("sw_edge2", A_SW, 32'h000000A5);

        applyStimulus(32'h00000010, 32'hDEADBEEF);
        readCheck("ram_rd", 32'h00000010, 32'hDEADBEEF);
        readCheck("ram_alias", 32'h00000010 + 4 * RAM_WORDS, 32'hDEADBEEF);
        memwrite  = 1'b1;
        addr      = 32'h00000010;
        writedata = 32'h12345678;
        #1;
        checkOutput("ram_rdw_old", readdata, 32'hDEADBEEF);
        tick();
        memwrite = 1'b0;
        readCheck("ram_rdw_new", 32'h00000010, 32'h12345678);

        applyStimulus(A_LOAD, 32'd3);
        applyStimulus(A_CTRL, 32'h1);
        readCheck("cnt3", A_COUNT, 32'd3);
        tick();
        readCheck("cnt2", A_COUNT, 32'd2);
        tick();
        readCheck("cnt1", A_COUNT, 32'd1);
        checkOutput("irq_before_exp", 32'(irq), 32'h0);
        tick();
        readCheck("cnt0", A_COUNT, 32'd0);
        checkOutput("irq_exp", 32'(irq), 32'h1);
        readCheck("ctrl_exp", A_CTRL, 32'h5);
        tick();
        readCheck("cnt_hold", A_COUNT, 32'd0);
        checkOutput("irq_sticky", 32'(irq), 32'h1);
        applyStimulus(A_CTRL, 32'h5);
        checkOutput("irq_w1c", 32'(irq), 32'h0);
        readCheck("ctrl_after_w1c", A_CTRL, 32'h1);

        applyStimulus(A_CTRL, 32'h0);
        applyStimulus(A_LOAD, 32'd2);
        applyStimulus(A_CTRL, 32'h3);
        readCheck("auto_c2", A_COUNT, 32'd2);
        tick();
        readCheck("auto_c1", A_COUNT, 32'd1);
        checkOutput("auto_irq0", 32'(irq), 32'h0);
        tick();
        readCheck("auto_reload", A_COUNT, 32'd2);
        checkOutput("auto_irq1", 32'(irq), 32'h1);
        applyStimulus(A_CTRL, 32'h7);
        checkOutput("auto_clr", 32'(irq), 32'h0);
        readCheck("auto_c1b", A_COUNT, 32'd1);
        applyStimulus(A_CTRL, 32'h7);
        checkOutput("set_beats_clr", 32'(irq), 32'h1);
        readCheck("auto_reload2", A_COUNT, 32'd2);
        applyStimulus(A_LOAD, 32'd9);
        readCheck("load_beats_dec", A_COUNT, 32'd9);
        applyStimulus(A_CTRL, 32'h4);
        readCheck("disable_cnt", A_COUNT, 32'd8);
        checkOutput("disable_irq", 32'(irq), 32'h0);
        tick();
        readCheck("idle_cnt", A_COUNT, 32'd8);
        applyStimulus(A_COUNT, 32'h55);
        readCheck("count_ro", A_COUNT, 32'd8);

        tick();
        addr = A_CYCLE;
        #1;
        v1 = readdata;
        tick();
        tick();
        v2 = readdata;
        checkOutput("cycle_diff", v2 - v1, 32'd2);
        force dut.cycle_q = 32'hFFFFFFFF;
        #1;
        checkOutput("cycle_force", readdata, 32'hFFFFFFFF);
        release dut.cycle_q;
        tick();
        checkOutput("cycle_wrap", readdata, 32'h0);

        applyStimulus(A_LED, 32'h3C);
        checkOutput("led_3c", 32'(led), 32'h3C);
        applyStimulus(A_LOAD, 32'd5);
        applyStimulus(A_CTRL, 32'h1);
        readCheck("mid_cnt5", A_COUNT, 32'd5);
        reset = 1'b0;
        #1;
        readCheck("rst_async_cnt", A_COUNT, 32'd0);
        readCheck("rst_async_ctrl", A_CTRL, 32'd0);
        checkOutput("rst_async_irq", 32'(irq), 32'h0);
        checkOutput("rst_async_led", 32'(led), 32'h0);
        reset = 1'b1;
        tick();
        tick();
        readCheck("post_rst_idle", A_COUNT, 32'd0);
        readCheck("ram_survives", 32'h00000010, 32'h12345678);
        applyStimulus(A_LED, 32'hFF);
        readCheck("led_rd", A_LED, 32'h000000FF);
        checkOutput("led_port", 32'(led), 32'hFF);
        readCheck("unmapped", 32'hFFFFFF20, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
